// File: rtl/mux_n_1_scan.sv
// mux_n_1_scan: N-input, WIDTH-bit registered multiplexer.
// Manual mode follows the (clamped) select input every cycle.
// Scan mode walks the channels round-robin and shows each one for dwell+1 cycles.
// Outputs y, ch, y_valid and wrap come straight from flops.
module mux_n_1_scan #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2,
  parameter int DWW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_flat,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  input  logic                 hold,
  input  logic [DWW-1:0]       dwell,
  output logic [WIDTH-1:0]     y,
  output logic [SELW-1:0]      ch,
  output logic                 y_valid,
  output logic                 wrap
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  // Number of slots addressable by a SELW-bit index.
  localparam int              NCH     = 2 ** SELW;
  localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

  // Effective channel for a raw select value: anything at or past N maps to N-1.
  function automatic logic [SELW-1:0] clamp_ch(input logic [SELW-1:0] s);
    logic [SELW-1:0] r;
    if (int'(s) >= N) begin
      r = LAST_CH;
    end else begin
      r = s;
    end
    return r;
  endfunction

  // Unpacked view of the inputs. Slots beyond N-1 mirror channel N-1, so
  // every index value reads a defined source.
  logic [WIDTH-1:0] in_arr_s [NCH];

  for (genvar k = 0; k < NCH; k++) begin : g_unpack
    localparam int SRC = (k < N) ? k : N - 1;
    assign in_arr_s[k] = in_flat[SRC*WIDTH +: WIDTH];
  end

  state_t           state_r,   state_nxt_s;
  logic [WIDTH-1:0] y_r,       y_nxt_s;
  logic [SELW-1:0]  ch_r,      ch_nxt_s;
  logic [DWW-1:0]   cnt_r,     cnt_nxt_s;
  logic             valid_r,   valid_nxt_s;
  logic             wrap_r,    wrap_nxt_s;
  logic [SELW-1:0]  sel_cl_s;

  assign sel_cl_s = clamp_ch(sel);

  // Next-state and next-output logic; defaults hold everything and keep wrap low.
  always_comb begin
    state_nxt_s = state_r;
    y_nxt_s     = y_r;
    ch_nxt_s    = ch_r;
    cnt_nxt_s   = cnt_r;
    valid_nxt_s = valid_r;
    wrap_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // First edge after reset: start from the clamped select in either mode.
        ch_nxt_s    = sel_cl_s;
        y_nxt_s     = in_arr_s[sel_cl_s];
        cnt_nxt_s   = {DWW{1'b0}};
        valid_nxt_s = 1'b1;
        if (mode) begin
          state_nxt_s = ST_SCAN;
        end else begin
          state_nxt_s = ST_MANUAL;
        end
      end
      ST_MANUAL: begin
        if (hold) begin
          state_nxt_s = state_r;
        end else begin
          // Scan entry also starts at clamp(sel) with a cleared dwell count.
          ch_nxt_s  = sel_cl_s;
          y_nxt_s   = in_arr_s[sel_cl_s];
          cnt_nxt_s = {DWW{1'b0}};
          if (mode) begin
            state_nxt_s = ST_SCAN;
          end else begin
            state_nxt_s = ST_MANUAL;
          end
        end
      end
      ST_SCAN: begin
        if (hold) begin
          state_nxt_s = state_r;
        end else begin
          // y always follows the channel in force before this edge.
          y_nxt_s = in_arr_s[ch_r];
          if (!mode) begin
            // Leaving scan: ch stays put for this edge, so it still matches y.
            state_nxt_s = ST_MANUAL;
            cnt_nxt_s   = {DWW{1'b0}};
          end else if (cnt_r >= dwell) begin
            // >= so that lowering dwell below cnt advances immediately.
            cnt_nxt_s = {DWW{1'b0}};
            if (ch_r == LAST_CH) begin
              ch_nxt_s   = {SELW{1'b0}};
              wrap_nxt_s = 1'b1;
            end else begin
              ch_nxt_s = ch_r + SELW'(1);
            end
          end else begin
            cnt_nxt_s = cnt_r + DWW'(1);
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        y_nxt_s     = {WIDTH{1'b0}};
        ch_nxt_s    = {SELW{1'b0}};
        cnt_nxt_s   = {DWW{1'b0}};
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears them without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      y_r     <= {WIDTH{1'b0}};
      ch_r    <= {SELW{1'b0}};
      cnt_r   <= {DWW{1'b0}};
      valid_r <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      y_r     <= y_nxt_s;
      ch_r    <= ch_nxt_s;
      cnt_r   <= cnt_nxt_s;
      valid_r <= valid_nxt_s;
      wrap_r  <= wrap_nxt_s;
    end
  end

  assign y       = y_r;
  assign ch      = ch_r;
  assign y_valid = valid_r;
  assign wrap    = wrap_r;

endmodule

// File: tb/tb_mux_n_1_scan.sv
// Testbench for mux_n_1_scan: an N=4 and an N=3 instance share one stimulus.
// Directed steps with fixed expectations come first, then randomized traffic
// is checked against a behavioural model of the channel and dwell rules.
module tb_mux_n_1_scan;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_flat;
  logic [1:0]   sel;
  logic         mode;
  logic         hold;
  logic [7:0]   dwell;

  logic [31:0]  y4, y3;
  logic [1:0]   ch4, ch3;
  logic         v4, v3, w4, w3;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural reference: phase 0 = idle, 1 = manual, 2 = scan.
  localparam int P_IDLE = 0;
  localparam int P_MAN  = 1;
  localparam int P_SCAN = 2;
  int          nn [2] = '{4, 3};
  int          m_phase [2];
  int          m_ch    [2];
  int          m_cnt   [2];
  logic [31:0] m_y     [2];
  logic        m_wrap  [2];
  logic        m_valid [2];

  int exp_seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  always #5 clk = ~clk;

  mux_n_1_scan #(.WIDTH(32), .N(4), .SELW(2), .DWW(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_flat(in_flat), .sel(sel), .mode(mode),
    .hold(hold), .dwell(dwell), .y(y4), .ch(ch4), .y_valid(v4), .wrap(w4)
  );

  mux_n_1_scan #(.WIDTH(32), .N(3), .SELW(2), .DWW(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_flat(in_flat[95:0]), .sel(sel), .mode(mode),
    .hold(hold), .dwell(dwell), .y(y3), .ch(ch3), .y_valid(v3), .wrap(w3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] chan(input int k);
    return in_flat[k*32 +: 32];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = P_IDLE;
      m_ch[i]    = 0;
      m_cnt[i]   = 0;
      m_y[i]     = 32'h0;
      m_wrap[i]  = 1'b0;
      m_valid[i] = 1'b0;
    end
  endtask

  // One rising edge of the reference, using the inputs that are stable now.
  task automatic model_step();
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        int c;
        c = (int'(sel) >= nn[i]) ? nn[i] - 1 : int'(sel);
        m_wrap[i] = 1'b0;
        if (m_phase[i] == P_IDLE) begin
          m_ch[i]    = c;
          m_y[i]     = chan(c);
          m_cnt[i]   = 0;
          m_valid[i] = 1'b1;
          m_phase[i] = mode ? P_SCAN : P_MAN;
        end else if (hold) begin
          m_wrap[i] = 1'b0;
        end else if (m_phase[i] == P_MAN) begin
          m_ch[i]  = c;
          m_y[i]   = chan(c);
          m_cnt[i] = 0;
          if (mode) m_phase[i] = P_SCAN;
        end else begin
          m_y[i] = chan(m_ch[i]);
          if (!mode) begin
            m_phase[i] = P_MAN;
            m_cnt[i]   = 0;
          end else if (m_cnt[i] >= int'(dwell)) begin
            m_cnt[i]  = 0;
            m_ch[i]   = (m_ch[i] + 1) % nn[i];
            m_wrap[i] = (m_ch[i] == 0);
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("y4",     y4,        m_y[0]);
    chk("ch4",    32'(ch4),  32'(m_ch[0]));
    chk("valid4", 32'(v4),   32'(m_valid[0]));
    chk("wrap4",  32'(w4),   32'(m_wrap[0]));
    chk("y3",     y3,        m_y[1]);
    chk("ch3",    32'(ch3),  32'(m_ch[1]));
    chk("valid3", 32'(v3),   32'(m_valid[1]));
    chk("wrap3",  32'(w3),   32'(m_wrap[1]));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    @(negedge clk);
  endtask

  // Drop rst_n between edges and check that outputs clear with no clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_y",     y4,       32'h0);
    chk("arst_ch",    32'(ch4), 32'd0);
    chk("arst_valid", 32'(v4),  32'd0);
    chk("arst_wrap",  32'(w4),  32'd0);
    check_all();
  endtask

  initial begin
    rst_n   = 1'b0;
    in_flat = {32'h0, 32'h44, 32'h33, 32'h22, 32'h11};
    sel     = 2'd2;
    mode    = 1'b0;
    hold    = 1'b0;
    dwell   = 8'd1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_y",     y4,      32'h0);
    chk("rst_valid", 32'(v4), 32'd0);
    check_all();

    // Manual select.
    rst_n = 1'b1;
    tick();
    chk("man_y",     y4,       32'h33);
    chk("man_ch",    32'(ch4), 32'd2);
    chk("man_valid", 32'(v4),  32'd1);
    sel = 2'd0;
    tick();
    chk("man_y_sel0", y4, 32'h11);

    // Scan with dwell=1 from channel 0.
    mode = 1'b1;
    for (int k = 0; k < 9; k++) begin
      int prev;
      prev = (k == 0) ? 0 : exp_seq[k-1];
      tick();
      chk("scan_ch",   32'(ch4), 32'(exp_seq[k]));
      chk("scan_wrap", 32'(w4),  (k == 8) ? 32'd1 : 32'd0);
      chk("scan_y",    y4,       32'h11 * 32'(prev + 1));
    end

    // Hold at ch=1, cnt=0 for five cycles.
    tick();
    tick();
    chk("pre_hold_ch", 32'(ch4), 32'd1);
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_ch",   32'(ch4), 32'd1);
      chk("hold_y",    y4,       32'h11);
      chk("hold_wrap", 32'(w4),  32'd0);
    end
    hold = 1'b0;
    tick();
    chk("post_hold_ch1", 32'(ch4), 32'd1);
    tick();
    chk("post_hold_ch2", 32'(ch4), 32'd2);

    // Mode switch back to manual at ch=2.
    mode = 1'b0;
    sel  = 2'd0;
    tick();
    chk("msw_wrap1", 32'(w4), 32'd0);
    tick();
    chk("msw_ch",    32'(ch4), 32'd0);
    chk("msw_wrap2", 32'(w4),  32'd0);
    mode = 1'b1;
    tick();
    chk("reenter_ch0a", 32'(ch4), 32'd0);
    tick();
    chk("reenter_ch0b", 32'(ch4), 32'd0);
    tick();
    chk("reenter_ch1",  32'(ch4), 32'd1);

    // Clamp: sel=3 on the N=3 instance.
    mode = 1'b0;
    sel  = 2'd3;
    tick();
    tick();
    chk("clamp_ch3", 32'(ch3), 32'd2);
    chk("clamp_y3",  y3,       32'h33);
    chk("clamp_y4",  y4,       32'h44);
    dwell = 8'd0;
    mode  = 1'b1;
    tick();
    chk("clamp_scan_start", 32'(ch3), 32'd2);
    tick();
    chk("clamp_scan_wrapch", 32'(ch3), 32'd0);
    chk("clamp_scan_wrap",   32'(w3),  32'd1);

    // Reset in the middle of a scan, at ch=3.
    for (int b = 0; b < 20 && ch4 != 2'd3; b++) tick();
    if (ch4 != 2'd3) chk("reach_ch3", 32'(ch4), 32'd3);
    async_reset();
    @(negedge clk);
    tick();
    sel   = 2'd1;
    rst_n = 1'b1;
    tick();
    chk("restart_ch",    32'(ch4), 32'd1);
    chk("restart_y",     y4,       32'h22);
    chk("restart_valid", 32'(v4),  32'd1);

    // Randomized traffic against the reference.
    for (int c = 0; c < 600; c++) begin
      in_flat = {$urandom, $urandom, $urandom, $urandom};
      sel     = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      hold = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) dwell = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
        #1 rst_n = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
